// File: rtl/result_uart_tx_if.sv
// Result bus plus UART status between the analyst stage and the TX block.
// Master drives the frame marker and results; slave returns line and status.
interface result_uart_tx_if;
    logic        new_frm;
    logic [11:0] centre_pos_x;
    logic [11:0] centre_pos_y;
    logic [9:0]  angle_x;
    logic [9:0]  angle_y;
    logic        chieu_xoay;
    logic        tx;
    logic        busy;
    logic        pkt_done;

    modport master (
        output new_frm, centre_pos_x, centre_pos_y,
        output angle_x, angle_y, chieu_xoay,
        input  tx, busy, pkt_done
    );

    modport slave (
        input  new_frm, centre_pos_x, centre_pos_y,
        input  angle_x, angle_y, chieu_xoay,
        output tx, busy, pkt_done
    );
endinterface

// File: rtl/result_uart_tx.sv
// Snapshots analyst results on each new-frame edge and sends them
// as an 11-byte 8N1 packet: 0xAA, nine payload bytes, checksum.
module result_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic             clk,
    input  logic             rst_n,
    result_uart_tx_if.slave  bus
);

    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e           state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [3:0]       byte_q, byte_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pend_q, pend_d;
    logic             r1_q, r2_q;
    logic [11:0]      snap_cx_q, snap_cy_q;
    logic [9:0]       snap_ax_q, snap_ay_q;
    logic             snap_cz_q;
    logic [10:0][7:0] pkt_q, pkt_ld;
    logic             load;
    logic             trig;
    logic [11:0]      cx, cy;
    logic [9:0]       ax, ay;
    logic             cz;
    logic [7:0]       sum;
    logic [7:0]       cur;
    logic [2:0]       nbit;

    assign trig = r1_q & ~r2_q;

    // A trig on the load edge means that edge's inputs are the newest snapshot
    always_comb begin
        cx = trig ? bus.centre_pos_x : snap_cx_q;
        cy = trig ? bus.centre_pos_y : snap_cy_q;
        ax = trig ? bus.angle_x      : snap_ax_q;
        ay = trig ? bus.angle_y      : snap_ay_q;
        cz = trig ? bus.chieu_xoay   : snap_cz_q;
        pkt_ld[0] = 8'hAA;
        pkt_ld[1] = {4'h0, cx[11:8]};
        pkt_ld[2] = cx[7:0];
        pkt_ld[3] = {4'h0, cy[11:8]};
        pkt_ld[4] = cy[7:0];
        pkt_ld[5] = {6'h0, ax[9:8]};
        pkt_ld[6] = ax[7:0];
        pkt_ld[7] = {6'h0, ay[9:8]};
        pkt_ld[8] = ay[7:0];
        pkt_ld[9] = {7'h0, cz};
        sum = 8'h00;
        for (int i = 1; i < 10; i++) begin
            sum = sum + pkt_ld[i];
        end
        pkt_ld[10] = sum;
    end

    assign cur  = pkt_q[byte_q];
    assign nbit = bit_q + 3'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pend_d  = pend_q;
        load    = 1'b0;
        if (trig && state_q != IDLE) begin
            pend_d = 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d = START;
                    cnt_d   = '0;
                    byte_d  = '0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    load    = 1'b1;
                end
            end
            START: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    tx_d    = cur[0];
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = nbit;
                        tx_d  = cur[nbit];
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (byte_q < 4'd10) begin
                        byte_d  = byte_q + 4'd1;
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        done_d = 1'b1;
                        pend_d = 1'b0;
                        if (pend_q || trig) begin
                            state_d = START;
                            byte_d  = '0;
                            tx_d    = 1'b0;
                            load    = 1'b1;
                        end else begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pend_q    <= 1'b0;
            r1_q      <= 1'b0;
            r2_q      <= 1'b0;
            snap_cx_q <= '0;
            snap_cy_q <= '0;
            snap_ax_q <= '0;
            snap_ay_q <= '0;
            snap_cz_q <= 1'b0;
            pkt_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pend_q  <= pend_d;
            r1_q    <= bus.new_frm;
            r2_q    <= r1_q;
            if (trig) begin
                snap_cx_q <= bus.centre_pos_x;
                snap_cy_q <= bus.centre_pos_y;
                snap_ax_q <= bus.angle_x;
                snap_ay_q <= bus.angle_y;
                snap_cz_q <= bus.chieu_xoay;
            end
            if (load) begin
                pkt_q <= pkt_ld;
            end
        end
    end

    assign bus.tx       = tx_q;
    assign bus.busy     = busy_q;
    assign bus.pkt_done = done_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench for result_uart_tx: decodes the serial line and
// checks packet bytes, latency, retrigger, level input and reset.
module tb_result_uart_tx;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   busy_cnt;
    int   done_cnt;
    logic [7:0] pk [0:10];
    logic [7:0] ex [0:10];
    logic [7:0] p1_b2;

    result_uart_tx_if bus ();

    result_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk or posedge clr) begin
        if (clr) begin
            busy_cnt <= 0;
            done_cnt <= 0;
        end else begin
            if (bus.busy === 1'b1) busy_cnt <= busy_cnt + 1;
            if (bus.pkt_done === 1'b1) done_cnt <= done_cnt + 1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        clr = 1'b1;
        #1;
        clr = 1'b0;
    endtask

    task automatic set_in(input logic [11:0] cx, input logic [11:0] cy,
                          input logic [9:0] ax, input logic [9:0] ay,
                          input logic cz);
        bus.centre_pos_x = cx;
        bus.centre_pos_y = cy;
        bus.angle_x      = ax;
        bus.angle_y      = ay;
        bus.chieu_xoay   = cz;
    endtask

    task automatic set_exp(input logic [11:0] cx, input logic [11:0] cy,
                           input logic [9:0] ax, input logic [9:0] ay,
                           input logic cz);
        logic [7:0] s;
        ex[0] = 8'hAA;
        ex[1] = {4'h0, cx[11:8]};
        ex[2] = cx[7:0];
        ex[3] = {4'h0, cy[11:8]};
        ex[4] = cy[7:0];
        ex[5] = {6'h0, ax[9:8]};
        ex[6] = ax[7:0];
        ex[7] = {6'h0, ay[9:8]};
        ex[8] = ay[7:0];
        ex[9] = {7'h0, cz};
        s = 8'h00;
        for (int i = 1; i < 10; i++) s = s + ex[i];
        ex[10] = s;
    endtask

    // Called at a negedge; returns one negedge after the frame edge is sampled
    task automatic pulse();
        bus.new_frm = 1'b1;
        @(negedge clk);
        bus.new_frm = 1'b0;
    endtask

    task automatic rx_byte(output logic [7:0] b);
        for (int i = 0; i < 2000 && bus.tx !== 1'b0; i++) @(negedge clk);
        chk("rx_start", bus.tx, 1'b0);
        repeat (CPB + CPB / 2) @(negedge clk);
        b[0] = bus.tx;
        for (int i = 1; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = bus.tx;
        end
        repeat (CPB) @(negedge clk);
        chk("rx_stop", bus.tx, 1'b1);
    endtask

    task automatic rx_pkt();
        logic [7:0] bt;
        for (int k = 0; k < 11; k++) begin
            rx_byte(bt);
            pk[k] = bt;
        end
    endtask

    task automatic chk_pkt(input string tag);
        for (int k = 0; k < 11; k++) begin
            chk($sformatf("%s_b%0d", tag, k), {24'h0, pk[k]}, {24'h0, ex[k]});
        end
    endtask

    initial begin
        bus.new_frm = 1'b0;
        set_in(12'h0, 12'h0, 10'h0, 10'h0, 1'b0);
        clear_counts();
        repeat (3) @(negedge clk);
        chk("rst_tx", bus.tx, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.pkt_done, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        set_in(12'h9C4, 12'h3E8, 10'h2A5, 10'h07F, 1'b1);
        set_exp(12'h9C4, 12'h3E8, 10'h2A5, 10'h07F, 1'b1);
        clear_counts();
        pulse();
        chk("lat_pre_tx", bus.tx, 1'b1);
        @(negedge clk);
        chk("lat_tx", bus.tx, 1'b0);
        chk("lat_busy", bus.busy, 1'b1);
        rx_pkt();
        chk_pkt("t1");
        chk("t1_b10_hand", {24'h0, pk[10]}, 32'hDF);
        chk("t1_b2_hand", {24'h0, pk[2]}, 32'hC4);
        repeat (5) @(negedge clk);
        chk("t1_busy_cyc", busy_cnt, 440);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_idle_busy", bus.busy, 1'b0);

        set_in(12'hFFF, 12'hFFF, 10'h3FF, 10'h3FF, 1'b1);
        set_exp(12'hFFF, 12'hFFF, 10'h3FF, 10'h3FF, 1'b1);
        bus.new_frm = 1'b1;
        @(negedge clk);
        @(negedge clk);
        set_in(12'h0, 12'h0, 10'h0, 10'h0, 1'b0);
        bus.new_frm = 1'b0;
        chk("t2_tx", bus.tx, 1'b0);
        rx_pkt();
        chk_pkt("t2");
        chk("t2_b10_hand", {24'h0, pk[10]}, 32'h21);
        repeat (10) @(negedge clk);

        set_in(12'h555, 12'h3E8, 10'h2A5, 10'h07F, 1'b0);
        clear_counts();
        pulse();
        @(negedge clk);
        fork
            begin
                rx_pkt();
                p1_b2 = pk[2];
                repeat (2) @(negedge clk);
                chk("t3_b2b_tx", bus.tx, 1'b0);
                chk("t3_b2b_busy", bus.busy, 1'b1);
                rx_pkt();
            end
            begin
                for (int c = 1; c <= 3; c++) begin
                    repeat (50) @(negedge clk);
                    bus.centre_pos_x = 12'(c);
                    pulse();
                end
            end
        join
        chk("t3_p1_b2", {24'h0, p1_b2}, 32'h55);
        set_exp(12'h003, 12'h3E8, 10'h2A5, 10'h07F, 1'b0);
        chk_pkt("t3b");
        chk("t3_p2_b2_hand", {24'h0, pk[2]}, 32'h03);
        repeat (60) @(negedge clk);
        chk("t3_done_cnt", done_cnt, 2);
        chk("t3_busy_cyc", busy_cnt, 880);
        chk("t3_idle_busy", bus.busy, 1'b0);

        clear_counts();
        bus.new_frm = 1'b1;
        repeat (1000) @(negedge clk);
        bus.new_frm = 1'b0;
        repeat (50) @(negedge clk);
        chk("t4_done_cnt", done_cnt, 1);
        chk("t4_busy_cyc", busy_cnt, 440);
        chk("t4_idle_busy", bus.busy, 1'b0);

        set_in(12'h123, 12'h000, 10'h155, 10'h2AA, 1'b0);
        pulse();
        @(negedge clk);
        repeat (170) @(negedge clk);
        chk("t5_pre_tx", bus.tx, 1'b0);
        chk("t5_pre_busy", bus.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_tx", bus.tx, 1'b1);
        chk("t5_rst_busy", bus.busy, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("t5_idle_tx", bus.tx, 1'b1);
        chk("t5_idle_busy", bus.busy, 1'b0);
        set_in(12'hABC, 12'h456, 10'h301, 10'h0F0, 1'b1);
        set_exp(12'hABC, 12'h456, 10'h301, 10'h0F0, 1'b1);
        pulse();
        @(negedge clk);
        chk("t5_new_tx", bus.tx, 1'b0);
        rx_pkt();
        chk_pkt("t5");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
